// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scanner: segment encodings and
// the anode-off mask helper.
package seg_scan_pkg;

  // Widest display the anode helper has to cover.
  localparam int MAX_DIG = 8;

  // Segment pattern with every segment dark, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Hex glyphs 0..F, bit order {g,f,e,d,c,b,a}, lower-case b and d.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Anodes are active-low, so "all off" is a ones mask over the used digits.
  function automatic logic [MAX_DIG-1:0] an_off_mask(input int ndig);
    logic [MAX_DIG-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIG; i++) begin
      m[i] = (i < ndig);
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Digit data in, segment/anode drive out for the seven-segment scanner.
interface seg_scan_if #(
  parameter int NDIG = 4
);

  logic [4*NDIG-1:0] iData;
  logic [NDIG-1:0]   iBlank;
  logic [NDIG-1:0]   iDp;
  logic              iLZS;
  logic [6:0]        oSeg;
  logic              oDp;
  logic [NDIG-1:0]   oAn;
  logic              oFrame;

  // The scanner itself.
  modport slave (
    input  iData, iBlank, iDp, iLZS,
    output oSeg, oDp, oAn, oFrame
  );

  // Whatever feeds digits to the scanner and watches its outputs.
  modport master (
    output iData, iBlank, iDp, iLZS,
    input  oSeg, oDp, oAn, oFrame
  );

endinterface

// File: rtl/seg_scan_hex7seg.sv
// Hex nibble to seven-segment glyph, purely combinational.
module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode seven-segment driver. Scans one digit per
// slot with a dark guard at the start of each slot, and snapshots its inputs
// once per frame so the displayed value never tears.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic      CLK,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int IDXW = $clog2(NDIG);

  localparam logic [DIVW-1:0]    DIV_LAST    = DIVW'(SCAN_DIV - 1);
  localparam logic [IDXW-1:0]    IDX_LAST    = IDXW'(NDIG - 1);
  localparam logic [MAX_DIG-1:0] AN_OFF_FULL = an_off_mask(NDIG);
  localparam logic [NDIG-1:0]    AN_OFF      = AN_OFF_FULL[NDIG-1:0];

  logic [DIVW-1:0]   div_q, div_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [4*NDIG-1:0] snap_data_q;
  logic [NDIG-1:0]   snap_blank_q;
  logic [NDIG-1:0]   snap_dp_q;
  logic              snap_lzs_q;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              frame_q;

  logic              slot_end;
  logic              frame_end;
  logic              in_guard;
  logic [NDIG-1:0]   lzs;
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic              cur_dp;
  logic [6:0]        cur_seg;

  // With no guard the comparison would be against zero, so drop it entirely.
  if (GUARD == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    assign in_guard = (div_q < DIVW'(GUARD));
  end

  // Next slot position and digit index.
  always_comb begin
    slot_end  = (div_q == DIV_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    div_d     = slot_end ? '0 : div_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is a leading zero when it and every digit above it is zero;
  // digit 0 always shows so a zero value still reads "0".
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lzs        = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (snap_data_q[4*k +: 4] == 4'h0);
      if (k > 0) begin
        lzs[k] = snap_lzs_q && upper_zero;
      end
    end
  end

  // Pick the snapshot fields of the digit currently being scanned.
  always_comb begin
    cur_digit = 4'h0;
    cur_blank = 1'b1;
    cur_dp    = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IDXW'(k)) begin
        cur_digit = snap_data_q[4*k +: 4];
        cur_blank = snap_blank_q[k] || lzs[k];
        cur_dp    = snap_dp_q[k];
      end
    end
  end

  hex7seg u_hex7seg (
    .hex_i (cur_digit),
    .seg_o (cur_seg)
  );

  // Output drive for the current slot; blanked digits keep their DP.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    if (!in_guard) begin
      an_d  = AN_OFF & ~(NDIG'(1) << idx_q);
      seg_d = cur_blank ? SEG_BLANK : cur_seg;
      dp_d  = cur_dp;
    end
  end

  // Slot divider and digit index.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // Frame snapshot; blank mask resets to all ones so the first frame is dark.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      snap_data_q  <= '0;
      snap_blank_q <= '1;
      snap_dp_q    <= '0;
      snap_lzs_q   <= 1'b0;
    end else if (frame_end) begin
      snap_data_q  <= bus.iData;
      snap_blank_q <= bus.iBlank;
      snap_dp_q    <= bus.iDp;
      snap_lzs_q   <= bus.iLZS;
    end
  end

  // Registered pad drive and frame pulse.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_end;
    end
  end

  assign bus.oAn    = an_q;
  assign bus.oSeg   = seg_q;
  assign bus.oDp    = dp_q;
  assign bus.oFrame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: cycle-level reference model from the display rules,
// a table of per-digit glyph expectations, reset/tearing sequences, random
// input churn, and a second GUARD=0 instance for anode exclusivity.
module tb_seg_scan;

  localparam int NDIG = 4;
  localparam int SD   = 4;
  localparam int GD   = 1;
  localparam int FL   = NDIG * SD;

  logic CLK = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 CLK = ~CLK;

  seg_scan_if #(.NDIG(NDIG)) bus ();
  seg_scan_if #(.NDIG(NDIG)) bus2 ();

  seg_scan #(.NDIG(NDIG), .SCAN_DIV(SD), .GUARD(GD)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seg_scan #(.NDIG(NDIG), .SCAN_DIV(2), .GUARD(0)) dut2 (
    .CLK   (CLK),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  int checks   = 0;
  int failures = 0;
  bit done2    = 1'b0;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bench-side inputs and model snapshot.
  logic [15:0] in_data;
  logic [3:0]  in_blank, in_dp;
  logic        in_lzs;
  logic [15:0] m_data;
  logic [3:0]  m_blank, m_dp;
  logic        m_lzs;
  int          e;
  bit          last_fr;

  bit          tab_active = 1'b0;
  logic [6:0]  tab_seg [4];
  logic [3:0]  tab_dp;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic        lzs;
    logic [6:0]  seg [4];
    logic [3:0]  edp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at t=%0t e=%0d: got %h, want %h", name, $time, e, act, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] b,
                        input logic [3:0] p, input logic z);
    in_data = d; in_blank = b; in_dp = p; in_lzs = z;
    bus.iData = d; bus.iBlank = b; bus.iDp = p; bus.iLZS = z;
  endtask

  task automatic model_reset();
    m_data = 16'h0; m_blank = 4'hF; m_dp = 4'h0; m_lzs = 1'b0;
    e = 0; last_fr = 1'b0;
  endtask

  // Expected drive after edge number t, from the snapshot held before it.
  task automatic compute_exp(input int t, output logic [3:0] an, output logic [6:0] seg,
                             output logic dp, output logic fr);
    int pos, idx;
    logic [15:0] above;
    logic lz;
    pos   = t % SD;
    idx   = (t / SD) % NDIG;
    fr    = ((t % FL) == FL - 1);
    above = m_data >> (4 * idx);
    lz    = m_lzs && (idx > 0) && (above == 16'h0);
    if (pos < GD) begin
      an = 4'hF; seg = 7'h00; dp = 1'b0;
    end else begin
      an  = ~(4'b0001 << idx);
      seg = (m_blank[idx] || lz) ? 7'h00 : hex_tab[above[3:0]];
      dp  = m_dp[idx];
    end
  endtask

  task automatic tick();
    logic [3:0] ean;
    logic [6:0] eseg;
    logic edp, efr;
    int pos, idx;
    compute_exp(e, ean, eseg, edp, efr);
    pos = e % SD;
    idx = (e / SD) % NDIG;
    @(posedge CLK);
    #1;
    check("oAn", int'(bus.oAn), int'(ean));
    check("oSeg", int'(bus.oSeg), int'(eseg));
    check("oDp", int'(bus.oDp), int'(edp));
    check("oFrame", int'(bus.oFrame), int'(efr));
    if (tab_active && pos >= GD) begin
      check("tab_seg", int'(bus.oSeg), int'(tab_seg[idx]));
      check("tab_dp", int'(bus.oDp), int'(tab_dp[idx]));
    end
    if (efr) begin
      m_data = in_data; m_blank = in_blank; m_dp = in_dp; m_lzs = in_lzs;
    end
    last_fr = efr;
    e++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sync_frame();
    int n;
    n = 0;
    while (!last_fr && n < 2 * FL) begin
      tick();
      n++;
    end
    if (!last_fr) begin
      checks++;
      failures++;
      $display("FAIL frame_sync: no oFrame within %0d cycles", 2 * FL);
    end
  endtask

  task automatic set_tab(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] p);
    tab_seg[0] = s0; tab_seg[1] = s1; tab_seg[2] = s2; tab_seg[3] = s3;
    tab_dp = p;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Second instance: GUARD=0, SCAN_DIV=2, 100 frames.
  initial begin
    int last, nfr, lows;
    bus2.iData = 16'h5A3C; bus2.iBlank = 4'h0; bus2.iDp = 4'h2; bus2.iLZS = 1'b0;
    rst2_n = 1'b0;
    last = -1; nfr = 0;
    #22;
    @(negedge CLK);
    rst2_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(posedge CLK);
      #1;
      lows = 0;
      for (int k = 0; k < NDIG; k++) if (!bus2.oAn[k]) lows++;
      check("g0_one_anode", lows, 1);
      if (bus2.oFrame) begin
        if (last < 0) check("g0_first_frame", c, 7);
        else          check("g0_frame_period", c - last, 8);
        last = c;
        nfr++;
      end
    end
    check("g0_frame_count", nfr, 100);
    done2 = 1'b1;
  end

  initial begin
    int w;
    vecs[0] = '{16'h0070, 4'h0, 4'h0, 1'b1, '{7'h3F, 7'h07, 7'h00, 7'h00}, 4'h0};
    vecs[1] = '{16'h0000, 4'h0, 4'h0, 1'b1, '{7'h3F, 7'h00, 7'h00, 7'h00}, 4'h0};
    vecs[2] = '{16'h8888, 4'h4, 4'h4, 1'b0, '{7'h7F, 7'h7F, 7'h00, 7'h7F}, 4'h4};
    vecs[3] = '{16'h00F0, 4'h0, 4'h0, 1'b0, '{7'h3F, 7'h71, 7'h3F, 7'h3F}, 4'h0};
    vecs[4] = '{16'h0005, 4'h0, 4'h8, 1'b1, '{7'h6D, 7'h00, 7'h00, 7'h00}, 4'h8};
    vecs[5] = '{16'h9E06, 4'h0, 4'h1, 1'b1, '{7'h7D, 7'h3F, 7'h79, 7'h6F}, 4'h1};
    vecs[6] = '{16'h0A00, 4'h1, 4'h0, 1'b1, '{7'h00, 7'h3F, 7'h77, 7'h00}, 4'h0};

    set_in(16'h1234, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    #22;
    check("rst_oAn", int'(bus.oAn), 15);
    check("rst_oSeg", int'(bus.oSeg), 0);
    check("rst_oDp", int'(bus.oDp), 0);
    check("rst_oFrame", int'(bus.oFrame), 0);
    @(negedge CLK);
    rst_n = 1'b1;
    model_reset();

    // First frame is dark, pulse at edge 15, then 1234 with a mid-frame change.
    run(FL);
    check("first_frame_pulse", int'(last_fr), 1);
    tab_active = 1'b1;
    set_tab(7'h66, 7'h4F, 7'h5B, 7'h06, 4'h0);
    run(6);
    set_in(16'hABCD, 4'h0, 4'h0, 1'b0);
    run(FL - 6);
    set_tab(7'h5E, 7'h39, 7'h7C, 7'h77, 4'h0);
    run(FL);

    // Table vectors: one frame to capture, one frame to display.
    for (int v = 0; v < 7; v++) begin
      sync_frame();
      set_in(vecs[v].data, vecs[v].blank, vecs[v].dp, vecs[v].lzs);
      tab_active = 1'b0;
      run(FL);
      set_tab(vecs[v].seg[0], vecs[v].seg[1], vecs[v].seg[2], vecs[v].seg[3], vecs[v].edp);
      tab_active = 1'b1;
      run(FL);
    end
    tab_active = 1'b0;

    // Reset at div=2 of digit 1.
    sync_frame();
    set_in(16'h4321, 4'h0, 4'h3, 1'b0);
    run(FL);
    run(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_oAn", int'(bus.oAn), 15);
    check("midrst_oSeg", int'(bus.oSeg), 0);
    check("midrst_oDp", int'(bus.oDp), 0);
    check("midrst_oFrame", int'(bus.oFrame), 0);
    @(negedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    model_reset();
    run(FL);
    check("midrst_frame_pulse", int'(last_fr), 1);
    run(FL);

    // Random input churn, changes landing at arbitrary cycles.
    for (int c = 0; c < 40 * FL; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        if ($urandom_range(0, 2) == 0) set_in({12'h000, 4'($urandom)}, 4'h0, 4'($urandom), 1'b1);
      end
      tick();
    end

    w = 0;
    while (!done2 && w < 2000) begin
      @(posedge CLK);
      w++;
    end
    if (!done2) begin
      checks++;
      failures++;
      $display("FAIL g0_done: second instance checker did not complete");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
